complete_bus_arbiter: RTL and testbench

- Shares the two complete buses among NUM_REQ functional-unit completion requesters (ALU, MUL, LSQ, ...).
- Each cycle it grants up to two requests in round-robin order and registers them onto complete bus 0 and complete bus 1.
- These buses feed the phys reg ready table set ports, the reservation-station wakeup logic and the ROB.
- Ordering rule: bus 0 is always filled before bus 1.

---
 rtl/core_types_pkg.sv | 23 ++
 rtl/rr_two_grant_picker.sv | 65 ++++++
 rtl/complete_bus_arbiter.sv | 131 +++++++++++++
 tb/tb_complete_bus_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_types_pkg.sv
// Shared core types: physical register tags, data words, ROB indices and the
// completion request payload carried on the complete buses.
package core_types_pkg;

  localparam int unsigned NUM_PHYS_REGS    = 128;
  localparam int unsigned NUM_ROB_ENTRIES  = 32;
  localparam int unsigned NUM_COMPLETE_REQ = 4;

  localparam int unsigned PHYS_REG_TAG_W = $clog2(NUM_PHYS_REGS);
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned ROB_INDEX_W    = $clog2(NUM_ROB_ENTRIES);

  typedef logic [PHYS_REG_TAG_W-1:0] phys_reg_tag_t;
  typedef logic [WORD_W-1:0]         word_t;
  typedef logic [ROB_INDEX_W-1:0]    rob_index_t;

  typedef struct packed {
    phys_reg_tag_t dest_phys_reg_tag;
    word_t         data;
    rob_index_t    rob_index;
  } complete_req_t;

endpackage

// File: rtl/rr_two_grant_picker.sv
// Combinational round-robin picker: finds the first two valid requesters in
// circular order starting at rr_ptr (rotate, two priority encodes, un-rotate).
module rr_two_grant_picker #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned LOG_NUM_REQ = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [LOG_NUM_REQ-1:0] rr_ptr,
  output logic                   g0_valid,
  output logic [LOG_NUM_REQ-1:0] g0_index,
  output logic                   g1_valid,
  output logic [LOG_NUM_REQ-1:0] g1_index
);

  logic [NUM_REQ-1:0]     rot_valid;
  logic [LOG_NUM_REQ-1:0] g0_rot;
  logic [LOG_NUM_REQ-1:0] g1_rot;

  // Modulo-NUM_REQ add; works for non-power-of-two requester counts.
  function automatic logic [LOG_NUM_REQ-1:0] wrap_add(
    input logic [LOG_NUM_REQ-1:0] base,
    input logic [LOG_NUM_REQ-1:0] off
  );
    logic [LOG_NUM_REQ:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= (LOG_NUM_REQ+1)'(NUM_REQ)) begin
      sum = sum - (LOG_NUM_REQ+1)'(NUM_REQ);
    end
    return sum[LOG_NUM_REQ-1:0];
  endfunction

  always_comb begin
    rot_valid = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      rot_valid[k] = req_valid[wrap_add(rr_ptr, LOG_NUM_REQ'(k))];
    end
  end

  always_comb begin
    g0_valid = 1'b0;
    g0_rot   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (rot_valid[k] && !g0_valid) begin
        g0_valid = 1'b1;
        g0_rot   = LOG_NUM_REQ'(k);
      end
    end
  end

  // Second encode skips the first winner; everything left lies after it.
  always_comb begin
    g1_valid = 1'b0;
    g1_rot   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (rot_valid[k] && (LOG_NUM_REQ'(k) != g0_rot) && !g1_valid) begin
        g1_valid = 1'b1;
        g1_rot   = LOG_NUM_REQ'(k);
      end
    end
  end

  assign g0_index = wrap_add(rr_ptr, g0_rot);
  assign g1_index = wrap_add(rr_ptr, g1_rot);

endmodule

// File: rtl/complete_bus_arbiter.sv
// Arbitrates NUM_REQ functional-unit completions onto two registered complete
// buses, round-robin, bus 0 always filled before bus 1.
module complete_bus_arbiter
  import core_types_pkg::*;
#(
  parameter int unsigned NUM_REQ     = NUM_COMPLETE_REQ,
  parameter int unsigned LOG_NUM_REQ = $clog2(NUM_REQ)
) (
  input  logic          CLK,
  input  logic          nRST,
  output logic          DUT_error,

  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  phys_reg_tag_t      req_dest_phys_reg_tag [NUM_REQ],
  input  word_t              req_data              [NUM_REQ],
  input  rob_index_t         req_rob_index         [NUM_REQ],

  output logic          complete_bus_0_valid,
  output phys_reg_tag_t complete_bus_0_dest_phys_reg_tag,
  output word_t         complete_bus_0_data,
  output rob_index_t    complete_bus_0_rob_index,

  output logic          complete_bus_1_valid,
  output phys_reg_tag_t complete_bus_1_dest_phys_reg_tag,
  output word_t         complete_bus_1_data,
  output rob_index_t    complete_bus_1_rob_index
);

  complete_req_t          req_payload [NUM_REQ];
  complete_req_t          g0_req;
  complete_req_t          g1_req;
  logic                   g0_valid;
  logic                   g1_valid;
  logic [LOG_NUM_REQ-1:0] g0_index;
  logic [LOG_NUM_REQ-1:0] g1_index;

  logic                   bus0_valid_d, bus0_valid_q;
  logic                   bus1_valid_d, bus1_valid_q;
  complete_req_t          bus0_d, bus0_q;
  complete_req_t          bus1_d, bus1_q;
  logic [LOG_NUM_REQ-1:0] rr_ptr_d, rr_ptr_q;
  logic                   dut_error_d, dut_error_q;

  function automatic logic [LOG_NUM_REQ-1:0] ptr_inc(input logic [LOG_NUM_REQ-1:0] p);
    if (p == LOG_NUM_REQ'(NUM_REQ - 1)) begin
      return '0;
    end
    return p + LOG_NUM_REQ'(1);
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_payload[i].dest_phys_reg_tag = req_dest_phys_reg_tag[i];
      req_payload[i].data              = req_data[i];
      req_payload[i].rob_index         = req_rob_index[i];
    end
  end

  rr_two_grant_picker #(
    .NUM_REQ    (NUM_REQ),
    .LOG_NUM_REQ(LOG_NUM_REQ)
  ) u_picker (
    .req_valid(req_valid),
    .rr_ptr   (rr_ptr_q),
    .g0_valid (g0_valid),
    .g0_index (g0_index),
    .g1_valid (g1_valid),
    .g1_index (g1_index)
  );

  assign g0_req = req_payload[g0_index];
  assign g1_req = req_payload[g1_index];

  // Grants are suppressed while reset is held so no handshake is lost.
  always_comb begin
    req_ready = '0;
    if (nRST) begin
      if (g0_valid) req_ready[g0_index] = 1'b1;
      if (g1_valid) req_ready[g1_index] = 1'b1;
    end
  end

  always_comb begin
    bus0_valid_d = g0_valid;
    bus1_valid_d = g1_valid;
    bus0_d       = bus0_q;
    bus1_d       = bus1_q;
    rr_ptr_d     = rr_ptr_q;
    if (g0_valid) begin
      bus0_d   = g0_req;
      rr_ptr_d = ptr_inc(g0_index);
    end
    if (g1_valid) begin
      bus1_d   = g1_req;
      rr_ptr_d = ptr_inc(g1_index);
    end
    dut_error_d = (g0_valid && (g0_req.dest_phys_reg_tag == '0)) ||
                  (g1_valid && ((g1_req.dest_phys_reg_tag == '0) ||
                                (g1_req.dest_phys_reg_tag == g0_req.dest_phys_reg_tag)));
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      bus0_valid_q <= 1'b0;
      bus1_valid_q <= 1'b0;
      bus0_q       <= '0;
      bus1_q       <= '0;
      rr_ptr_q     <= '0;
      dut_error_q  <= 1'b0;
    end else begin
      bus0_valid_q <= bus0_valid_d;
      bus1_valid_q <= bus1_valid_d;
      bus0_q       <= bus0_d;
      bus1_q       <= bus1_d;
      rr_ptr_q     <= rr_ptr_d;
      dut_error_q  <= dut_error_d;
    end
  end

  assign DUT_error                        = dut_error_q;
  assign complete_bus_0_valid             = bus0_valid_q;
  assign complete_bus_0_dest_phys_reg_tag = bus0_q.dest_phys_reg_tag;
  assign complete_bus_0_data              = bus0_q.data;
  assign complete_bus_0_rob_index         = bus0_q.rob_index;
  assign complete_bus_1_valid             = bus1_valid_q;
  assign complete_bus_1_dest_phys_reg_tag = bus1_q.dest_phys_reg_tag;
  assign complete_bus_1_data              = bus1_q.data;
  assign complete_bus_1_rob_index         = bus1_q.rob_index;

endmodule

// File: tb/tb_complete_bus_arbiter.sv
// Self-checking bench for complete_bus_arbiter: directed scenarios plus a
// randomized run checked against a queue-free round-robin reference model.
module tb_complete_bus_arbiter;
  import core_types_pkg::*;

  localparam int N = 4;

  logic          CLK;
  logic          nRST;
  logic          DUT_error;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  phys_reg_tag_t req_tag  [N];
  word_t         req_data [N];
  rob_index_t    req_rob  [N];
  logic          b0_valid, b1_valid;
  phys_reg_tag_t b0_tag, b1_tag;
  word_t         b0_data, b1_data;
  rob_index_t    b0_rob, b1_rob;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Reference model state
  int            m_ptr;
  logic          e_b0v, e_b1v, e_err;
  complete_req_t e_b0, e_b1;

  complete_bus_arbiter dut (
    .CLK                             (CLK),
    .nRST                            (nRST),
    .DUT_error                       (DUT_error),
    .req_valid                       (req_valid),
    .req_ready                       (req_ready),
    .req_dest_phys_reg_tag           (req_tag),
    .req_data                        (req_data),
    .req_rob_index                   (req_rob),
    .complete_bus_0_valid            (b0_valid),
    .complete_bus_0_dest_phys_reg_tag(b0_tag),
    .complete_bus_0_data             (b0_data),
    .complete_bus_0_rob_index        (b0_rob),
    .complete_bus_1_valid            (b1_valid),
    .complete_bus_1_dest_phys_reg_tag(b1_tag),
    .complete_bus_1_data             (b1_data),
    .complete_bus_1_rob_index        (b1_rob)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // First two valid requesters scanning circularly from the model pointer.
  task automatic model_grant(output logic [N-1:0] rdy, output int ga, output int gb);
    ga  = -1;
    gb  = -1;
    rdy = '0;
    if (nRST) begin
      for (int j = 0; j < N; j++) begin
        int i;
        i = (m_ptr + j) % N;
        if (req_valid[i]) begin
          if (ga < 0) ga = i;
          else if (gb < 0) gb = i;
        end
      end
    end
    if (ga >= 0) rdy[ga] = 1'b1;
    if (gb >= 0) rdy[gb] = 1'b1;
  endtask

  // Advance one clock and update the model's expected bus state.
  task automatic step();
    logic [N-1:0] rdy;
    int ga, gb;
    model_grant(rdy, ga, gb);
    @(posedge CLK);
    if (!nRST) begin
      e_b0v = 1'b0; e_b1v = 1'b0; e_err = 1'b0;
      e_b0  = '0;   e_b1  = '0;   m_ptr = 0;
    end else begin
      e_b0v = (ga >= 0);
      e_b1v = (gb >= 0);
      if (ga >= 0) e_b0 = '{req_tag[ga], req_data[ga], req_rob[ga]};
      if (gb >= 0) e_b1 = '{req_tag[gb], req_data[gb], req_rob[gb]};
      e_err = (ga >= 0 && req_tag[ga] == 0) ||
              (gb >= 0 && (req_tag[gb] == 0 || req_tag[gb] == req_tag[ga]));
      if (gb >= 0) m_ptr = (gb + 1) % N;
      else if (ga >= 0) m_ptr = (ga + 1) % N;
    end
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    req_valid = 4'b1111;
    for (int i = 0; i < N; i++) begin
      req_tag[i]  = 7'(10 + i);
      req_data[i] = $urandom;
      req_rob[i]  = 5'(i);
    end
    step();
    step();
    chk_cnt++;
    if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", req_ready);
    else pass_cnt++;
    chk_cnt++;
    if ({b0_valid, b1_valid, DUT_error} !== 3'b000)
      $display("FAIL reset_valids: got b0=%b b1=%b err=%b want 0", b0_valid, b1_valid, DUT_error);
    else pass_cnt++;
    chk_cnt++;
    if ({b0_tag, b0_data, b0_rob} !== '0) $display("FAIL reset_payload: got tag=%0d data=%h rob=%0d want 0", b0_tag, b0_data, b0_rob);
    else pass_cnt++;
    nRST = 1'b1;
    #1;
    chk_cnt++;
    if (req_ready !== 4'b0011) $display("FAIL reset_first_grant: got %b want 0011", req_ready);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (!(b0_valid === 1'b1 && b0_tag === 7'd10 && b1_valid === 1'b1 && b1_tag === 7'd11))
      $display("FAIL reset_first_bus: got b0=%b/%0d b1=%b/%0d want 1/10 1/11", b0_valid, b0_tag, b1_valid, b1_tag);
    else pass_cnt++;
    chk_cnt++;
    if (dut.rr_ptr_q !== 2'd2) $display("FAIL reset_rr_ptr: got %0d want 2", dut.rr_ptr_q);
    else pass_cnt++;
    req_valid = '0;
    step();
  endtask

  task automatic test_single();
    req_valid   = 4'b0100;
    req_tag[2]  = 7'd12;
    req_data[2] = 32'hDEADBEEF;
    req_rob[2]  = 5'd5;
    #1;
    chk_cnt++;
    if (req_ready !== 4'b0100) $display("FAIL single_ready: got %b want 0100", req_ready);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (!(b0_valid === 1'b1 && b0_tag === 7'd12 && b0_data === 32'hDEADBEEF && b0_rob === 5'd5))
      $display("FAIL single_bus0: got v=%b tag=%0d data=%h rob=%0d want 1/12/deadbeef/5", b0_valid, b0_tag, b0_data, b0_rob);
    else pass_cnt++;
    chk_cnt++;
    if (b1_valid !== 1'b0) $display("FAIL single_bus1: got %b want 0", b1_valid);
    else pass_cnt++;
    chk_cnt++;
    if (dut.rr_ptr_q !== 2'd3) $display("FAIL single_rr_ptr: got %0d want 3", dut.rr_ptr_q);
    else pass_cnt++;
    req_valid = '0;
  endtask

  task automatic test_wrap();
    req_valid  = 4'b1001;
    req_tag[3] = 7'd20;
    req_tag[0] = 7'd21;
    #1;
    chk_cnt++;
    if (req_ready !== 4'b1001) $display("FAIL wrap_ready: got %b want 1001", req_ready);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (!(b0_valid === 1'b1 && b0_tag === 7'd20 && b1_valid === 1'b1 && b1_tag === 7'd21))
      $display("FAIL wrap_bus: got b0=%b/%0d b1=%b/%0d want 1/20 1/21", b0_valid, b0_tag, b1_valid, b1_tag);
    else pass_cnt++;
    chk_cnt++;
    if (dut.rr_ptr_q !== 2'd1) $display("FAIL wrap_rr_ptr: got %0d want 1", dut.rr_ptr_q);
    else pass_cnt++;
    req_valid = 4'b1000;
    step();
    chk_cnt++;
    if (dut.rr_ptr_q !== 2'd0) $display("FAIL wrap_to_zero: got %0d want 0", dut.rr_ptr_q);
    else pass_cnt++;
    req_valid = '0;
  endtask

  task automatic test_all_four();
    logic [N-1:0]  exp_rdy;
    phys_reg_tag_t exp_t0, exp_t1;
    req_valid = 4'b1111;
    for (int i = 0; i < N; i++) req_tag[i] = 7'(10 + i);
    for (int c = 0; c < 4; c++) begin
      exp_rdy = (c % 2 == 1) ? 4'b1100 : 4'b0011;
      exp_t0  = (c % 2 == 1) ? 7'd12 : 7'd10;
      exp_t1  = (c % 2 == 1) ? 7'd13 : 7'd11;
      #1;
      chk_cnt++;
      if (req_ready !== exp_rdy) $display("FAIL all4_ready c%0d: got %b want %b", c, req_ready, exp_rdy);
      else pass_cnt++;
      step();
      chk_cnt++;
      if (!(b0_valid === 1'b1 && b0_tag === exp_t0 && b1_valid === 1'b1 && b1_tag === exp_t1))
        $display("FAIL all4_bus c%0d: got %0d,%0d want %0d,%0d", c, b0_tag, b1_tag, exp_t0, exp_t1);
      else pass_cnt++;
    end
    req_valid = '0;
  endtask

  task automatic test_error();
    req_valid  = 4'b0101;
    req_tag[0] = 7'd9;
    req_tag[2] = 7'd9;
    #1;
    step();
    chk_cnt++;
    if (!(DUT_error === 1'b1 && b0_valid === 1'b1 && b1_valid === 1'b1 && b0_tag === 7'd9 && b1_tag === 7'd9))
      $display("FAIL error_dup_tag: got err=%b b0=%b/%0d b1=%b/%0d want 1 1/9 1/9", DUT_error, b0_valid, b0_tag, b1_valid, b1_tag);
    else pass_cnt++;
    req_valid  = 4'b0010;
    req_tag[1] = 7'd0;
    step();
    chk_cnt++;
    if (!(DUT_error === 1'b1 && b0_valid === 1'b1 && b1_valid === 1'b0))
      $display("FAIL error_zero_tag: got err=%b b0v=%b b1v=%b want 1 1 0", DUT_error, b0_valid, b1_valid);
    else pass_cnt++;
    req_valid = '0;
    step();
    chk_cnt++;
    if (!(DUT_error === 1'b0 && b0_valid === 1'b0 && b1_valid === 1'b0))
      $display("FAIL error_idle: got err=%b b0v=%b b1v=%b want 0 0 0", DUT_error, b0_valid, b1_valid);
    else pass_cnt++;
  endtask

  task automatic test_random(input int cycles);
    logic [N-1:0] rdy;
    int ga, gb, worst;
    int wait_cnt [N];
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    req_valid = '0;
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && ($urandom_range(0, 1) == 1)) begin
          req_valid[i] = 1'b1;
          req_tag[i]   = 7'($urandom_range(0, 127));
          req_data[i]  = $urandom;
          req_rob[i]   = 5'($urandom_range(0, 31));
        end
      end
      #1;
      model_grant(rdy, ga, gb);
      chk_cnt++;
      if (req_ready !== rdy) $display("FAIL rand_ready c%0d: got %b want %b", c, req_ready, rdy);
      else pass_cnt++;
      worst = 0;
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && !rdy[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        if (wait_cnt[i] > worst) worst = wait_cnt[i];
      end
      chk_cnt++;
      if (worst >= 2) $display("FAIL rand_fairness c%0d: got wait %0d want <2", c, worst);
      else pass_cnt++;
      step();
      chk_cnt++;
      if ({b0_valid, b1_valid, DUT_error} !== {e_b0v, e_b1v, e_err})
        $display("FAIL rand_flags c%0d: got b0v=%b b1v=%b err=%b want %b %b %b",
                 c, b0_valid, b1_valid, DUT_error, e_b0v, e_b1v, e_err);
      else pass_cnt++;
      if (e_b0v) begin
        chk_cnt++;
        if ({b0_tag, b0_data, b0_rob} !== e_b0)
          $display("FAIL rand_bus0 c%0d: got %0d/%h/%0d want %0d/%h/%0d", c, b0_tag, b0_data, b0_rob,
                   e_b0.dest_phys_reg_tag, e_b0.data, e_b0.rob_index);
        else pass_cnt++;
      end
      if (e_b1v) begin
        chk_cnt++;
        if ({b1_tag, b1_data, b1_rob} !== e_b1)
          $display("FAIL rand_bus1 c%0d: got %0d/%h/%0d want %0d/%h/%0d", c, b1_tag, b1_data, b1_rob,
                   e_b1.dest_phys_reg_tag, e_b1.data, e_b1.rob_index);
        else pass_cnt++;
      end
      chk_cnt++;
      if (b1_valid === 1'b1 && b0_valid !== 1'b1) $display("FAIL rand_bus_order c%0d: got b1v=1 with b0v=%b", c, b0_valid);
      else pass_cnt++;
      req_valid = req_valid & ~rdy;
    end
    req_valid = '0;
    step();
  endtask

  initial begin
    nRST      = 1'b0;
    req_valid = '0;
    for (int i = 0; i < N; i++) begin
      req_tag[i]  = '0;
      req_data[i] = '0;
      req_rob[i]  = '0;
    end
    m_ptr = 0;
    e_b0v = 1'b0; e_b1v = 1'b0; e_err = 1'b0;
    e_b0  = '0;   e_b1  = '0;
    @(negedge CLK);
    test_reset();
    test_single();
    test_wrap();
    test_all_four();
    test_error();
    test_random(10000);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
